lsu: RTL

// - Load/store unit, directly downstream of the execute stage: consumes the ALU result as the effective address and rs2 as store data.
// - Runs a request/grant/rvalid transaction on the data RAM port.
// - Does byte-lane steering for stores and extract/sign-extension for loads.
// - Stalls the pipeline until the access completes or times out.

---
 rtl/lsu.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: request/grant/rvalid data-RAM port, store lane steering, load extract/extend, timeout abort.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            lsu_ld_i,
  input  logic            lsu_st_i,
  input  logic [2:0]      lsu_size_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wr_data_i,
  output logic            lsu_stall_o,
  output logic            lsu_done_o,
  output logic [XLEN-1:0] lsu_rd_data_o,
  output logic            lsu_err_o,
  output logic            lsu_misalign_o,
  output logic            dram_req_o,
  output logic            dram_we_o,
  output logic [XLEN-1:0] dram_addr_o,
  output logic [3:0]      dram_be_o,
  output logic [XLEN-1:0] dram_wr_data_o,
  input  logic            dram_gnt_i,
  input  logic            dram_rvalid_i,
  input  logic [XLEN-1:0] dram_rd_data_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_off;
  logic            r_we;
  logic            r_req;
  logic            r_done;
  logic            r_err;
  logic            r_misalign;
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rd_data;

  logic [1:0]      w_off_eff;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic            w_misalign;
  logic            w_timeout;
  logic [XLEN-1:0] w_ld_data;
  logic            w_stall;

  // Shift the addressed lane down, then sign- or zero-extend by funct3; unused encodings act as LW.
  function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [31:0] word,
                                            input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  ld_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_extend = {24'h000000, sh[7:0]};
      3'b101:  ld_extend = {16'h0000, sh[15:0]};
      default: ld_extend = word;
    endcase
  endfunction

  // Request decode at accept time: aligned lane offset, byte enables, replicated write data.
  always_comb begin
    w_off_eff  = 2'b00;
    w_be       = 4'b1111;
    w_wdata    = lsu_wr_data_i;
    w_misalign = 1'b0;
    case (lsu_size_i[1:0])
      2'b00: begin
        w_off_eff = lsu_addr_i[1:0];
        w_be      = 4'b0001 << lsu_addr_i[1:0];
        w_wdata   = {4{lsu_wr_data_i[7:0]}};
      end
      2'b01: begin
        w_off_eff = {lsu_addr_i[1], 1'b0};
        w_be      = 4'b0011 << {lsu_addr_i[1], 1'b0};
        w_wdata   = {2{lsu_wr_data_i[15:0]}};
      end
      default: begin
        w_off_eff = 2'b00;
        w_be      = 4'b1111;
        w_wdata   = lsu_wr_data_i;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if (lsu_size_i[1:0] == 2'b01) begin
      w_misalign = lsu_addr_i[0];
    end else if (lsu_size_i[1]) begin
      w_misalign = (lsu_addr_i[1:0] != 2'b00);
    end else begin
      w_misalign = 1'b0;
    end
`else
    w_misalign = 1'b0;
`endif
  end

  // Pipeline hold: asserted the moment a request appears in IDLE and while the access is outstanding.
  always_comb begin
    w_stall = 1'b0;
    if (r_state == S_IDLE) begin
      w_stall = lsu_ld_i | lsu_st_i;
    end else begin
      w_stall = (r_state == S_REQ) | (r_state == S_WAIT);
    end
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_ld_data = ld_extend(r_size, dram_rd_data_i, r_off);

  // Access sequencer; completion takes priority over timeout in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_size     <= 3'b000;
      r_off      <= 2'b00;
      r_we       <= 1'b0;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
      r_rd_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu_ld_i || lsu_st_i) begin
            r_we    <= ~lsu_ld_i;
            r_size  <= lsu_size_i;
            r_off   <= w_off_eff;
            r_addr  <= {lsu_addr_i[XLEN-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            if (w_misalign) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
              r_rd_data  <= '0;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (dram_gnt_i && r_we) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state   <= S_DONE;
            r_req     <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_rd_data <= '0;
          end else if (dram_gnt_i) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (dram_rvalid_i) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_rd_data <= w_ld_data;
          end else if (w_timeout) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_rd_data <= '0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
          r_misalign <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_req      <= 1'b0;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
          r_misalign <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_stall_o    = w_stall;
  assign lsu_done_o     = r_done;
  assign lsu_rd_data_o  = r_rd_data;
  assign lsu_err_o      = r_err;
  assign lsu_misalign_o = r_misalign;
  assign dram_req_o     = r_req;
  assign dram_we_o      = r_we;
  assign dram_addr_o    = r_addr;
  assign dram_be_o      = r_be;
  assign dram_wr_data_o = r_wdata;

endmodule
